core_amo_seq: RTL and testbench
===============================

// Module: core_amo_seq
// PURPOSE
//  Sequences A-extension ops (LR.W, SC.W, AMO*.W) over the core's single word memory port.
//  Holds the LR reservation and runs the read -> ALU -> write steps of each AMO.
//  Returns the rd value or an exception cause to the core.
//  Sits between core control (CTRL_AMO path) and the data-memory request port.
// PARAMETERS
//  XLEN      32  data/address width; only 32 supported
//  RSV_LSB   2   reservation granule = addr[XLEN-1:RSV_LSB] (word)
// PORTS
//  clk             in   1     clock
//  rst_n           in   1     reset; one clock; reset is asynchronous and active-low
//  req_valid       in   1     AMO request from core
//  req_ready       out  1     high only in IDLE
//  req_op          in   5     amo_op_e (funct5)
//  req_addr        in   XLEN  rs1 (effective address)
//  req_data        in   XLEN  rs2 operand
//  resp_valid      out  1     result valid; held until resp_ready
//  resp_ready      in   1     core accepts result
//  resp_data       out  XLEN  value for rd
//  resp_err        out  1     exception; resp_data invalid
//  resp_cause      out  6     exception_e code when resp_err
//  mem_req_valid   out  1     memory request
//  mem_req_ready   in   1     memory accepts request
//  mem_dir         out  1     mem_dir_e
//  mem_addr        out  XLEN  word address, always aligned
//  mem_wdata       out  XLEN  store data
//  mem_resp_valid  in   1     read data / write ack; always >=1 cycle after req handshake
//  mem_rdata       in   XLEN  read data
//  mem_err         in   1     access fault, qualified by mem_resp_valid
//  rsv_kill        in   1     clears reservation (trap, xRET, context switch)
//  snoop_valid     in   1     other-agent store observed
//  snoop_addr      in   XLEN  address of observed store
// BEHAVIOUR
//  Reset: FSM=IDLE, rsv_valid=0. Outputs req_ready=1; all others 0.
//  States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RESP. Request regs captured on req handshake.
//  IDLE, accept, then decode:
//   addr[1:0]!=0 -> RESP, err. Cause LOAD_MISALIGNED(4) for LR, STORE_MISALIGNED(6) otherwise.
//   op not in amo_op_e -> RESP, err, ILLEGAL_INSTR(2).
//   LR, or any AMO other than LR/SC -> RD_REQ.
//   SC: if rsv_valid && rsv_addr==addr[XLEN-1:RSV_LSB] -> WR_REQ (wdata=rs2).
//   SC otherwise -> RESP, data=1.
//   Every SC clears rsv_valid on accept.
//  RD_REQ: valid=1, dir=READ, held until ready -> RD_WAIT.
//  RD_WAIT, on mem_resp_valid:
//   mem_err -> RESP, err. Cause LOAD_ACCESS_FAULT(5) for LR, STORE_ACCESS_FAULT(7) for AMO.
//   LR -> RESP, data=rdata; set rsv_valid and rsv_addr.
//   AMO -> latch old=rdata; wdata=f(old,rs2) -> WR_REQ.
//  f: SWAP=rs2, ADD, XOR, OR, AND; MIN/MAX signed; MINU/MAXU unsigned; full 32-bit wrap.
//  WR_REQ: valid=1, dir=WRITE, held until ready -> WR_WAIT.
//  WR_WAIT, on mem_resp_valid:
//   mem_err -> RESP, err, STORE_ACCESS_FAULT(7).
//   else -> RESP. data=old for AMO, 0 for SC.
//  RESP: resp_valid=1 and resp fields stable until resp_ready, then IDLE.
//   req_ready is not asserted in the same cycle.
//  Any error clears rsv_valid. A non-SC AMO to the reserved granule also clears it.
//  rsv_kill, or snoop_valid matching the granule, clears rsv_valid in any state.
//   Same-cycle LR set loses to the kill; reservation ends cleared.
//  mem_addr = {addr[XLEN-1:2],2'b00}; request signals never change while valid && !ready.
//  Min latency with zero-wait memory:
//   AMO: resp_valid 5 cycles after accept.
//   LR, SC pass: 3 cycles. SC fail, misaligned, illegal: 1 cycle.
//  rst_n low mid-op: immediate IDLE, no further mem request, reservation lost.
//   An outstanding mem response after reset is ignored.
// TESTING
//  AMOADD mem[0x100]=5, rs2=3 -> read then write 8. resp_data=5. resp_valid 5 cycles after accept.
//  LR 0x200 (mem=0xA5), then SC 0x200 rs2=7 -> write 7, resp 0.
//   A second SC to 0x200 -> resp 1 with no mem request.
//  LR 0x200, then snoop_valid at 0x202 -> SC 0x200 returns 1, no write.
//   Same sequence with rsv_kill gives the same result.
//  AMOMIN mem=0xFFFFFFFF, rs2=1 -> writes 0xFFFFFFFF. AMOMINU same operands -> writes 1.
//  AMOSWAP addr 0x103 -> err cause 6, no mem req.
//   AMOOR read with mem_err -> err cause 7, no write.
//  mem_req_ready low for 4 cycles -> addr/dir/wdata stable.
//   resp_ready low for 3 cycles -> resp held.
//   rst_n pulse in WR_WAIT -> IDLE, req_ready=1.

Source files
------------

// File: rtl/core_amo_seq_if.sv
// Core/memory-side bundle for the atomic-op sequencer: request, response, memory port and
// reservation-kill inputs. slave = sequencer view, master = environment view.
interface core_amo_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            req_valid;
    logic            req_ready;
    logic [4:0]      req_op;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] req_data;
    logic            resp_valid;
    logic            resp_ready;
    logic [XLEN-1:0] resp_data;
    logic            resp_err;
    logic [5:0]      resp_cause;
    logic            mem_req_valid;
    logic            mem_req_ready;
    logic            mem_dir;
    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic            mem_resp_valid;
    logic [XLEN-1:0] mem_rdata;
    logic            mem_err;
    logic            rsv_kill;
    logic            snoop_valid;
    logic [XLEN-1:0] snoop_addr;

    modport slave (
        input  req_valid, req_op, req_addr, req_data, resp_ready,
        input  mem_req_ready, mem_resp_valid, mem_rdata, mem_err,
        input  rsv_kill, snoop_valid, snoop_addr,
        output req_ready, resp_valid, resp_data, resp_err, resp_cause,
        output mem_req_valid, mem_dir, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_data, resp_ready,
        output mem_req_ready, mem_resp_valid, mem_rdata, mem_err,
        output rsv_kill, snoop_valid, snoop_addr,
        input  req_ready, resp_valid, resp_data, resp_err, resp_cause,
        input  mem_req_valid, mem_dir, mem_addr, mem_wdata
    );
endinterface

// File: rtl/core_amo_seq.sv
// Sequences LR.W / SC.W / AMO*.W over a single word memory port, owns the LR reservation
// and returns rd or an exception cause to the core.
module core_amo_seq #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RSV_LSB = 2
) (
    input logic           clk,
    input logic           rst_n,
    core_amo_seq_if.slave bus
);
    localparam int unsigned GW = XLEN - RSV_LSB;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_REQ  = 3'd1;
    localparam logic [2:0] S_RD_WAIT = 3'd2;
    localparam logic [2:0] S_WR_REQ  = 3'd3;
    localparam logic [2:0] S_WR_WAIT = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SWAP = 5'b00001;
    localparam logic [4:0] OP_LR   = 5'b00010;
    localparam logic [4:0] OP_SC   = 5'b00011;
    localparam logic [4:0] OP_XOR  = 5'b00100;
    localparam logic [4:0] OP_OR   = 5'b01000;
    localparam logic [4:0] OP_AND  = 5'b01100;
    localparam logic [4:0] OP_MIN  = 5'b10000;
    localparam logic [4:0] OP_MAX  = 5'b10100;
    localparam logic [4:0] OP_MINU = 5'b11000;
    localparam logic [4:0] OP_MAXU = 5'b11100;

    localparam logic [5:0] C_ILLEGAL = 6'd2;
    localparam logic [5:0] C_LD_MIS  = 6'd4;
    localparam logic [5:0] C_LD_ACC  = 6'd5;
    localparam logic [5:0] C_ST_MIS  = 6'd6;
    localparam logic [5:0] C_ST_ACC  = 6'd7;

    logic [2:0]      r_state;
    logic [4:0]      r_op;
    logic [XLEN-1:2] r_waddr;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_old;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_resp_data;
    logic            r_resp_err;
    logic [5:0]      r_resp_cause;
    logic            r_resp_valid;
    logic            r_req_ready;
    logic            r_mem_valid;
    logic            r_mem_dir;
    logic            r_rsv_valid;
    logic [GW-1:0]   r_rsv_addr;

    logic [2:0]      w_state;
    logic [4:0]      w_op;
    logic [XLEN-1:2] w_waddr;
    logic [XLEN-1:0] w_rs2;
    logic [XLEN-1:0] w_old;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_resp_data;
    logic            w_resp_err;
    logic [5:0]      w_resp_cause;
    logic            w_rsv_set;
    logic            w_rsv_clr;
    logic            w_legal;
    logic [XLEN-1:0] w_alu;
    logic [GW-1:0]   w_snoop_gran;
    logic            w_kill_cur;
    logic            w_kill_new;
    logic            w_req_hit;
    logic            w_unused_snoop;

    assign w_snoop_gran   = bus.snoop_addr[XLEN-1:RSV_LSB];
    assign w_unused_snoop = ^bus.snoop_addr[RSV_LSB-1:0];
    assign w_kill_cur     = bus.rsv_kill || (bus.snoop_valid && (w_snoop_gran == r_rsv_addr));
    assign w_kill_new     = bus.rsv_kill ||
                            (bus.snoop_valid && (w_snoop_gran == r_waddr[XLEN-1:RSV_LSB]));
    // An SC that arrives together with a kill already sees the reservation as lost.
    assign w_req_hit      = r_rsv_valid && !w_kill_cur &&
                            (r_rsv_addr == bus.req_addr[XLEN-1:RSV_LSB]);

    always_comb begin
        w_legal = 1'b0;
        case (bus.req_op)
            OP_ADD, OP_SWAP, OP_LR, OP_SC, OP_XOR, OP_OR, OP_AND,
            OP_MIN, OP_MAX, OP_MINU, OP_MAXU: w_legal = 1'b1;
            default:                          w_legal = 1'b0;
        endcase
    end

    // AMO read-modify-write function on the returned memory word.
    always_comb begin
        w_alu = r_rs2;
        case (r_op)
            OP_ADD:  w_alu = bus.mem_rdata + r_rs2;
            OP_XOR:  w_alu = bus.mem_rdata ^ r_rs2;
            OP_OR:   w_alu = bus.mem_rdata | r_rs2;
            OP_AND:  w_alu = bus.mem_rdata & r_rs2;
            OP_MIN:  w_alu = ($signed(bus.mem_rdata) < $signed(r_rs2)) ? bus.mem_rdata : r_rs2;
            OP_MAX:  w_alu = ($signed(bus.mem_rdata) > $signed(r_rs2)) ? bus.mem_rdata : r_rs2;
            OP_MINU: w_alu = (bus.mem_rdata < r_rs2) ? bus.mem_rdata : r_rs2;
            OP_MAXU: w_alu = (bus.mem_rdata > r_rs2) ? bus.mem_rdata : r_rs2;
            default: w_alu = r_rs2;
        endcase
    end

    always_comb begin
        w_state      = r_state;
        w_op         = r_op;
        w_waddr      = r_waddr;
        w_rs2        = r_rs2;
        w_old        = r_old;
        w_wdata      = r_wdata;
        w_resp_data  = r_resp_data;
        w_resp_err   = r_resp_err;
        w_resp_cause = r_resp_cause;
        w_rsv_set    = 1'b0;
        w_rsv_clr    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.req_valid) begin
                    w_op         = bus.req_op;
                    w_waddr      = bus.req_addr[XLEN-1:2];
                    w_rs2        = bus.req_data;
                    w_resp_data  = '0;
                    w_resp_err   = 1'b0;
                    w_resp_cause = '0;
                    if (bus.req_addr[1:0] != 2'b00) begin
                        w_state      = S_RESP;
                        w_resp_err   = 1'b1;
                        w_resp_cause = (bus.req_op == OP_LR) ? C_LD_MIS : C_ST_MIS;
                        w_rsv_clr    = 1'b1;
                    end else if (!w_legal) begin
                        w_state      = S_RESP;
                        w_resp_err   = 1'b1;
                        w_resp_cause = C_ILLEGAL;
                        w_rsv_clr    = 1'b1;
                    end else if (bus.req_op == OP_SC) begin
                        w_rsv_clr = 1'b1;
                        if (w_req_hit) begin
                            w_state = S_WR_REQ;
                            w_wdata = bus.req_data;
                        end else begin
                            w_state     = S_RESP;
                            w_resp_data = XLEN'(1);
                        end
                    end else begin
                        w_state = S_RD_REQ;
                        if (bus.req_op != OP_LR && w_req_hit) w_rsv_clr = 1'b1;
                    end
                end
            end
            S_RD_REQ: if (bus.mem_req_ready) w_state = S_RD_WAIT;
            S_RD_WAIT: begin
                if (bus.mem_resp_valid) begin
                    if (bus.mem_err) begin
                        w_state      = S_RESP;
                        w_resp_err   = 1'b1;
                        w_resp_cause = (r_op == OP_LR) ? C_LD_ACC : C_ST_ACC;
                        w_rsv_clr    = 1'b1;
                    end else if (r_op == OP_LR) begin
                        w_state     = S_RESP;
                        w_resp_data = bus.mem_rdata;
                        w_rsv_set   = 1'b1;
                    end else begin
                        w_state = S_WR_REQ;
                        w_old   = bus.mem_rdata;
                        w_wdata = w_alu;
                    end
                end
            end
            S_WR_REQ: if (bus.mem_req_ready) w_state = S_WR_WAIT;
            S_WR_WAIT: begin
                if (bus.mem_resp_valid) begin
                    w_state = S_RESP;
                    if (bus.mem_err) begin
                        w_resp_err   = 1'b1;
                        w_resp_cause = C_ST_ACC;
                        w_rsv_clr    = 1'b1;
                    end else begin
                        w_resp_data = (r_op == OP_SC) ? '0 : r_old;
                    end
                end
            end
            S_RESP:  if (bus.resp_ready) w_state = S_IDLE;
            default: w_state = S_IDLE;
        endcase
    end

    // State, captured request and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_op         <= '0;
            r_waddr      <= '0;
            r_rs2        <= '0;
            r_old        <= '0;
            r_wdata      <= '0;
            r_resp_data  <= '0;
            r_resp_err   <= 1'b0;
            r_resp_cause <= '0;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_mem_valid  <= 1'b0;
            r_mem_dir    <= 1'b0;
        end else begin
            r_state      <= w_state;
            r_op         <= w_op;
            r_waddr      <= w_waddr;
            r_rs2        <= w_rs2;
            r_old        <= w_old;
            r_wdata      <= w_wdata;
            r_resp_data  <= w_resp_data;
            r_resp_err   <= w_resp_err;
            r_resp_cause <= w_resp_cause;
            r_resp_valid <= (w_state == S_RESP);
            r_req_ready  <= (w_state == S_IDLE);
            r_mem_valid  <= (w_state == S_RD_REQ) || (w_state == S_WR_REQ);
            r_mem_dir    <= (w_state == S_WR_REQ);
        end
    end

    // Reservation: kills win over a same-cycle LR set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsv_valid <= 1'b0;
            r_rsv_addr  <= '0;
        end else if (w_rsv_set) begin
            r_rsv_valid <= !w_kill_new;
            r_rsv_addr  <= r_waddr[XLEN-1:RSV_LSB];
        end else if (w_kill_cur || w_rsv_clr) begin
            r_rsv_valid <= 1'b0;
        end
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_data     = r_resp_data;
    assign bus.resp_err      = r_resp_err;
    assign bus.resp_cause    = r_resp_cause;
    assign bus.mem_req_valid = r_mem_valid;
    assign bus.mem_dir       = r_mem_dir;
    assign bus.mem_addr      = {r_waddr, 2'b00};
    assign bus.mem_wdata     = r_wdata;
endmodule

// File: tb/tb_core_amo_seq.sv
// Directed self-checking bench for core_amo_seq with a behavioural word memory.
module tb_core_amo_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;

    core_amo_seq_if bus ();

    core_amo_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] ADD = 5'b00000, SWAP = 5'b00001, LR = 5'b00010, SC = 5'b00011;
    localparam logic [4:0] XOR = 5'b00100, OR = 5'b01000, AND = 5'b01100;
    localparam logic [4:0] MIN = 5'b10000, MAX = 5'b10100, MINU = 5'b11000, MAXU = 5'b11100;

    logic [31:0] mem [int unsigned];
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    int          mem_stall = 0;
    int          stall_left = 0;
    logic        err_next = 1'b0;
    logic        pend = 1'b0;
    logic        pend_err;
    logic [31:0] pend_data;
    logic        stalling = 1'b0;
    logic [31:0] s_addr, s_wdata;
    logic        s_dir;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Memory: decides ready on the negedge, answers one cycle after the handshake.
    always @(negedge clk) begin
        bus.mem_resp_valid = 1'b0;
        bus.mem_err        = 1'b0;
        if (pend) begin
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata      = pend_data;
            bus.mem_err        = pend_err;
            pend               = 1'b0;
        end
        if (bus.mem_req_valid && rst_n) begin
            if (stalling) begin
                check("stall_addr", bus.mem_addr, s_addr);
                check("stall_dir", 32'(bus.mem_dir), 32'(s_dir));
                check("stall_wdata", bus.mem_wdata, s_wdata);
            end else begin
                s_addr  = bus.mem_addr;
                s_dir   = bus.mem_dir;
                s_wdata = bus.mem_wdata;
            end
            if (stall_left > 0) begin
                stalling          = 1'b1;
                bus.mem_req_ready = 1'b0;
                stall_left--;
            end else begin
                stalling          = 1'b0;
                bus.mem_req_ready = 1'b1;
                check("mem_align", 32'(bus.mem_addr[1:0]), 32'd0);
                pend      = 1'b1;
                pend_err  = err_next;
                err_next  = 1'b0;
                pend_data = 32'h0;
                if (!bus.mem_dir) begin
                    rd_cnt++;
                    pend_data = mem.exists(bus.mem_addr) ? mem[bus.mem_addr] : 32'h0;
                end else begin
                    wr_cnt++;
                    if (!pend_err) mem[bus.mem_addr] = bus.mem_wdata;
                end
                stall_left = mem_stall;
            end
        end else begin
            bus.mem_req_ready = 1'b0;
        end
    end

    // One core request: checks result, latency (negedges from accept) and resp holding.
    task automatic run(input string tag, input logic [4:0] op, input logic [31:0] addr,
                       input logic [31:0] data, input int hold, input logic [31:0] exp_data,
                       input logic exp_err, input logic [5:0] exp_cause, input int exp_lat);
        int          lat;
        logic [31:0] d0;
        @(negedge clk);
        check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_addr  = addr;
        bus.req_data  = data;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        lat = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            lat++;
            if (bus.resp_valid) break;
        end
        check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
        check({tag, "_cause"}, 32'(bus.resp_cause), 32'(exp_cause));
        if (!exp_err) check({tag, "_data"}, bus.resp_data, exp_data);
        check({tag, "_busy"}, 32'(bus.req_ready), 32'd0);
        d0 = bus.resp_data;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(bus.resp_valid), 32'd1);
            check({tag, "_hold_data"}, bus.resp_data, d0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1 bus.resp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_idle"}, 32'(bus.req_ready), 32'd1);
        check({tag, "_resp_drop"}, 32'(bus.resp_valid), 32'd0);
    endtask

    task automatic pulse_snoop(input logic [31:0] a);
        @(negedge clk);
        bus.snoop_valid = 1'b1;
        bus.snoop_addr  = a;
        @(negedge clk);
        bus.snoop_valid = 1'b0;
    endtask

    task automatic pulse_kill();
        @(negedge clk);
        bus.rsv_kill = 1'b1;
        @(negedge clk);
        bus.rsv_kill = 1'b0;
    endtask

    int rd0, wr0;

    initial begin
        rst_n             = 1'b0;
        bus.req_valid     = 1'b0;
        bus.req_op        = '0;
        bus.req_addr      = '0;
        bus.req_data      = '0;
        bus.resp_ready    = 1'b0;
        bus.rsv_kill      = 1'b0;
        bus.snoop_valid   = 1'b0;
        bus.snoop_addr    = '0;
        bus.mem_req_ready = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_rdata     = '0;
        bus.mem_err       = 1'b0;
        mem[32'h100] = 32'd5;
        mem[32'h200] = 32'hA5;
        mem[32'h300] = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 32'(bus.req_ready), 32'd1);
        check("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
        check("rst_resp_data", bus.resp_data, 32'd0);
        check("rst_mem_addr", bus.mem_addr, 32'd0);

        run("amoadd", ADD, 32'h100, 32'd3, 0, 32'd5, 1'b0, 6'd0, 5);
        check("amoadd_mem", mem[32'h100], 32'd8);

        run("lr1", LR, 32'h200, 32'd0, 0, 32'hA5, 1'b0, 6'd0, 3);
        run("sc1", SC, 32'h200, 32'd7, 0, 32'd0, 1'b0, 6'd0, 3);
        check("sc1_mem", mem[32'h200], 32'd7);
        rd0 = rd_cnt; wr0 = wr_cnt;
        run("sc2", SC, 32'h200, 32'd9, 0, 32'd1, 1'b0, 6'd0, 1);
        check("sc2_nomem", 32'(rd_cnt + wr_cnt), 32'(rd0 + wr0));

        run("lr_snp", LR, 32'h200, 32'd0, 0, 32'd7, 1'b0, 6'd0, 3);
        pulse_snoop(32'h202);
        rd0 = rd_cnt; wr0 = wr_cnt;
        run("sc_snp", SC, 32'h200, 32'd9, 0, 32'd1, 1'b0, 6'd0, 1);
        check("sc_snp_nomem", 32'(rd_cnt + wr_cnt), 32'(rd0 + wr0));

        run("lr_kill", LR, 32'h200, 32'd0, 0, 32'd7, 1'b0, 6'd0, 3);
        pulse_kill();
        run("sc_kill", SC, 32'h200, 32'd9, 0, 32'd1, 1'b0, 6'd0, 1);
        check("sc_kill_mem", mem[32'h200], 32'd7);

        run("lr_osnp", LR, 32'h200, 32'd0, 0, 32'd7, 1'b0, 6'd0, 3);
        pulse_snoop(32'h204);
        run("sc_osnp", SC, 32'h200, 32'h55, 0, 32'd0, 1'b0, 6'd0, 3);
        check("sc_osnp_mem", mem[32'h200], 32'h55);

        run("lr_amo", LR, 32'h200, 32'd0, 0, 32'h55, 1'b0, 6'd0, 3);
        run("amo_rsv", ADD, 32'h200, 32'd0, 0, 32'h55, 1'b0, 6'd0, 5);
        run("sc_amo", SC, 32'h200, 32'd1, 0, 32'd1, 1'b0, 6'd0, 1);

        run("amomin", MIN, 32'h300, 32'd1, 0, 32'hFFFF_FFFF, 1'b0, 6'd0, 5);
        check("amomin_mem", mem[32'h300], 32'hFFFF_FFFF);
        run("amominu", MINU, 32'h300, 32'd1, 0, 32'hFFFF_FFFF, 1'b0, 6'd0, 5);
        check("amominu_mem", mem[32'h300], 32'd1);
        run("amomax", MAX, 32'h300, 32'h8000_0000, 0, 32'd1, 1'b0, 6'd0, 5);
        check("amomax_mem", mem[32'h300], 32'd1);
        run("amomaxu", MAXU, 32'h300, 32'h8000_0000, 0, 32'd1, 1'b0, 6'd0, 5);
        check("amomaxu_mem", mem[32'h300], 32'h8000_0000);
        run("amoand", AND, 32'h300, 32'h0000_FFFF, 0, 32'h8000_0000, 1'b0, 6'd0, 5);
        check("amoand_mem", mem[32'h300], 32'd0);
        run("add_a", ADD, 32'h300, 32'hFFFF_FFFF, 0, 32'd0, 1'b0, 6'd0, 5);
        run("add_wrap", ADD, 32'h300, 32'd2, 0, 32'hFFFF_FFFF, 1'b0, 6'd0, 5);
        check("add_wrap_mem", mem[32'h300], 32'd1);

        rd0 = rd_cnt; wr0 = wr_cnt;
        run("swap_mis", SWAP, 32'h103, 32'd1, 0, 32'd0, 1'b1, 6'd6, 1);
        run("lr_mis", LR, 32'h102, 32'd0, 0, 32'd0, 1'b1, 6'd4, 1);
        run("sc_mis", SC, 32'h201, 32'd0, 0, 32'd0, 1'b1, 6'd6, 1);
        run("illegal", 5'b00101, 32'h100, 32'd0, 0, 32'd0, 1'b1, 6'd2, 1);
        check("err_nomem", 32'(rd_cnt + wr_cnt), 32'(rd0 + wr0));

        rd0 = rd_cnt; wr0 = wr_cnt;
        err_next = 1'b1;
        run("or_fault", OR, 32'h100, 32'hFF, 0, 32'd0, 1'b1, 6'd7, 3);
        check("or_fault_rd", 32'(rd_cnt), 32'(rd0 + 1));
        check("or_fault_wr", 32'(wr_cnt), 32'(wr0));
        check("or_fault_mem", mem[32'h100], 32'd8);
        err_next = 1'b1;
        run("lr_fault", LR, 32'h100, 32'd0, 0, 32'd0, 1'b1, 6'd5, 3);

        mem_stall  = 4;
        stall_left = 4;
        run("xor_stall", XOR, 32'h100, 32'hF0, 3, 32'd8, 1'b0, 6'd0, 13);
        check("xor_stall_mem", mem[32'h100], 32'hF8);
        mem_stall  = 0;
        stall_left = 0;
        run("swap", SWAP, 32'h100, 32'h1234_5678, 0, 32'hF8, 1'b0, 6'd0, 5);
        check("swap_mem", mem[32'h100], 32'h1234_5678);

        // Reset while the AMO write is outstanding; its late ack must be ignored.
        run("lr_rst", LR, 32'h300, 32'd0, 0, 32'd1, 1'b0, 6'd0, 3);
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = ADD;
        bus.req_addr  = 32'h100;
        bus.req_data  = 32'd1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        begin
            int seen;
            seen = 0;
            for (int i = 0; i < 50; i++) begin
                @(negedge clk);
                if (bus.mem_req_valid && bus.mem_dir) begin
                    seen = 1;
                    break;
                end
            end
            check("rst_wr_seen", 32'(seen), 32'd1);
        end
        @(posedge clk);
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        rd0 = rd_cnt; wr0 = wr_cnt;
        repeat (2) @(negedge clk);
        check("midrst_req_ready", 32'(bus.req_ready), 32'd1);
        check("midrst_resp_valid", 32'(bus.resp_valid), 32'd0);
        check("midrst_mem_valid", 32'(bus.mem_req_valid), 32'd0);
        repeat (3) @(negedge clk);
        check("midrst_nomem", 32'(rd_cnt + wr_cnt), 32'(rd0 + wr0));
        run("sc_rst", SC, 32'h300, 32'd5, 0, 32'd1, 1'b0, 6'd0, 1);
        check("sc_rst_mem", mem[32'h300], 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
